// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched bit pattern MSB first on w_out,
// with optional repeats separated by zero-bit gaps, paced by a tick enable.
module sequence_generator #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned REP_W   = 4,
  parameter int unsigned GAP     = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [REP_W-1:0]   repeat_count,
  input  logic               tick,
  output logic               w_out,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         state
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   pass_q, pass_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               done_d, err_d, len_ok;

  assign len_ok = (length != '0) && (length <= LEN_W'(MAX_LEN));
  assign state  = state_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_d   = pattern;
            len_d   = length;
            idx_d   = IDX_W'(length - 1'b1);
            pass_d  = repeat_count;
            state_d = S_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else if (pass_q != '0) begin
            pass_d  = pass_q - 1'b1;
            idx_d   = IDX_W'(len_q - 1'b1);
            gap_d   = '0;
            state_d = (GAP > 0) ? S_GAP : S_SHIFT;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(GAP - 1)) state_d = S_SHIFT;
          else                          gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      gap_q   <= '0;
      w_out   <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      gap_q   <= gap_d;
      w_out   <= (state_d == S_SHIFT) ? pat_d[idx_d] : 1'b0;
      valid   <= (state_d == S_SHIFT);
      busy    <= (state_d != S_IDLE);
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: expected per-edge output words
// are queued from a bench-side expansion of each run and popped every edge.
module tb_sequence_generator;

  localparam int unsigned GAP_T = 2;

  logic       clock, resetn, start, tick;
  logic [7:0] pattern;
  logic [3:0] length, repeat_count;
  logic       w_out, valid, busy, done, err;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  sequence_generator #(
    .MAX_LEN(8),
    .LEN_W  (4),
    .REP_W  (4),
    .GAP    (GAP_T)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .pattern     (pattern),
    .length      (length),
    .repeat_count(repeat_count),
    .tick        (tick),
    .w_out       (w_out),
    .valid       (valid),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .state       (state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // {w_out, valid, busy, done, err, state}
  function automatic logic [6:0] mk(input logic w, input logic v, input logic b,
                                    input logic d, input logic e, input logic [1:0] st);
    return {w, v, b, d, e, st};
  endfunction

  function automatic logic [6:0] obs();
    return {w_out, valid, busy, done, err, state};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one run starting at the next edge and checks every edge through done.
  // chaos: pulse start and alter the inputs while the run is busy.
  task automatic run(input string name, input logic [7:0] pat, input logic [3:0] len,
                     input logic [3:0] rep, input int unsigned per, input bit chaos);
    logic [6:0] q[$];
    logic [6:0] x, o;
    int unsigned e;
    for (int p = 0; p <= int'(rep); p++) begin
      for (int i = int'(len) - 1; i >= 0; i--)
        for (int unsigned k = 0; k < per; k++) q.push_back(mk(pat[i], 1, 1, 0, 0, 2'b01));
      if (p < int'(rep))
        for (int unsigned g = 0; g < GAP_T * per; g++) q.push_back(mk(0, 0, 1, 0, 0, 2'b10));
    end
    q.push_back(mk(0, 0, 0, 1, 0, 2'b00));
    start = 1'b1; pattern = pat; length = len; repeat_count = rep;
    e = 0;
    while (q.size() > 0) begin
      tick = (e % per == 0);
      step();
      x = q.pop_front();
      o = obs();
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL %s edge %0d: got %b want %b", name, e, o, x);
      end
      start = 1'b0;
      if (chaos && e == 1) begin
        start = 1'b1; pattern = ~pat; length = 4'd3; repeat_count = 4'd5;
      end
      e++;
    end
    tick = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; tick = 1'b1;
    pattern = '0; length = '0; repeat_count = '0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (obs() !== 7'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", obs()); end
    @(negedge clock) resetn = 1'b1;
    step();
    total++;
    if (obs() !== 7'b0) begin bad++; $display("FAIL reset_idle: got %b want 0", obs()); end
  endtask

  task automatic test_single();
    run("single", 8'b0000_1101, 4'd4, 4'd0, 1, 0);
    step();
    total++;
    if (obs() !== 7'b0) begin bad++; $display("FAIL single_after_done: got %b want 0", obs()); end
  endtask

  task automatic test_repeat();
    run("repeat_gap", 8'b0000_1101, 4'd4, 4'd1, 1, 0);
    step();
  endtask

  task automatic test_slow_tick();
    run("slow_tick", 8'b1011_0111, 4'd8, 4'd0, 3, 0);
    step();
  endtask

  task automatic test_boundaries();
    run("len1_rep2", 8'b0000_0001, 4'd1, 4'd2, 1, 0);
    step();
    run("len8_rep2", 8'b1010_0101, 4'd8, 4'd2, 2, 0);
    step();
  endtask

  task automatic test_err();
    logic [3:0] bad_len[3] = '{4'd0, 4'd9, 4'd15};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; length = bad_len[i]; pattern = 8'hFF;
      step();
      total++;
      if (obs() !== mk(0, 0, 0, 0, 1, 2'b00)) begin
        bad++; $display("FAIL err_pulse len=%0d: got %b want 0000100", bad_len[i], obs());
      end
      start = 1'b0;
      step();
      total++;
      if (obs() !== 7'b0) begin
        bad++; $display("FAIL err_clear len=%0d: got %b want 0", bad_len[i], obs());
      end
    end
  endtask

  task automatic test_ignore_changes();
    run("ignore_changes", 8'b0000_1101, 4'd4, 4'd1, 1, 1);
    step();
    total++;
    if (obs() !== 7'b0) begin bad++; $display("FAIL ignore_after: got %b want 0", obs()); end
  endtask

  task automatic test_back_to_back();
    run("b2b_first", 8'b0000_1101, 4'd4, 4'd0, 1, 0);
    run("b2b_second", 8'b0000_0110, 4'd3, 4'd1, 1, 0);
    step();
  endtask

  task automatic test_async_reset();
    start = 1'b1; pattern = 8'b0000_1101; length = 4'd4; repeat_count = 4'd0; tick = 1'b1;
    step();
    start = 1'b0;
    step();
    #3 resetn = 1'b0;
    #1;
    total++;
    if (obs() !== 7'b0) begin bad++; $display("FAIL async_reset: got %b want 0", obs()); end
    @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    step();
    total++;
    if (obs() !== 7'b0) begin bad++; $display("FAIL post_reset_idle: got %b want 0", obs()); end
    run("post_reset_run", 8'b0000_1101, 4'd4, 4'd0, 1, 0);
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_slow_tick();
    test_boundaries();
    test_err();
    test_ignore_changes();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter that emits a programmable bit sequence, MSB first, on a single-bit line `w_out`. It is the transmit end of the serial bit-stream interface consumed by the lab's sequence detectors, where one bit is consumed per detector clock. Each pattern pass can be repeated, and zero-bit gaps between passes flush detector history. A `tick` enable throttles the bit rate, so the same block drives either a free-running detector or a slow, pushbutton-stepped one.

## Interface
- `MAX_LEN`, 8, maximum pattern length in bits; `pattern` width.
- `LEN_W`, 4, width of `length`; must hold values up to `MAX_LEN`.
- `REP_W`, 4, width of `repeat_count`.
- `GAP`, 2, number of zero bits inserted between passes; 0 means no gap.
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request to transmit; sampled only in IDLE.
- `pattern` in `MAX_LEN`: bits to send; bit `length-1` is sent first, bit 0 last.
- `length` in `LEN_W`: number of pattern bits, legal range 1..`MAX_LEN`.
- `repeat_count` in `REP_W`: number of extra passes; total passes = `repeat_count`+1.
- `tick` in 1: bit-advance enable; the current bit is consumed on a rising edge with `tick`=1.
- `w_out` out 1: serial data; 0 whenever not in SHIFT.
- `valid` out 1: 1 while `w_out` carries a pattern bit (SHIFT).
- `busy` out 1: 1 in SHIFT or GAP.
- `done` out 1: one-cycle pulse after the final bit of the final pass is consumed.
- `err` out 1: one-cycle pulse when `start` is rejected for an illegal `length`.
- `state` out 2: current state, IDLE=00, SHIFT=01, GAP=10 (for LEDR display).

## Operation
- All outputs are registered. Reset forces IDLE, clears the internal pattern, counters and indices, and sets every output to 0.
- **IDLE**
  - `start`=1 and 1 ≤ `length` ≤ `MAX_LEN`: latch `pattern`, `length` and `repeat_count`; set bit index to `length`-1 and pass counter to `repeat_count`; go to SHIFT.
  - `start`=1 with `length`=0 or `length` > `MAX_LEN`: pulse `err` for one cycle; stay in IDLE.
- **SHIFT**
  - `w_out` = latched pattern[index]; `valid`=1.
  - On `tick`=1 with index>0: decrement index.
  - On `tick`=1 with index=0 and pass counter>0: decrement pass counter; reload index to `length`-1; go to GAP if `GAP`>0, else stay in SHIFT.
  - On `tick`=1 with index=0 and pass counter=0: go to IDLE and pulse `done`.
- **GAP**
  - `w_out`=0, `valid`=0.
  - Count `GAP` ticks, then go to SHIFT.
- `start` is ignored while `busy`=1. Changes on `pattern`, `length` or `repeat_count` during a run have no effect.
- `tick`=0 holds the state, the index, the counters and `w_out`.
- `tick` has no effect in IDLE.

## Timing
- `start` sampled at edge k (IDLE): from edge k, `w_out` = first bit, `valid`=1, `busy`=1, `state`=01.
- Each bit stays on `w_out` from the edge after the previous consuming tick up to and including its own consuming tick edge.
- With `tick` held at 1, an N-bit, single-pass run occupies edges k..k+N-1 with valid data. At edge k+N: `done`=1, `busy`=0, `valid`=0, `w_out`=0, `state`=00. At edge k+N+1: `done`=0.
- A `start` sampled in the same cycle that `done` is high is accepted, because the block is already in IDLE. This allows back-to-back runs with one idle cycle between them.
- Total run length with `tick`=1 throughout: (`repeat_count`+1)·`length` + `repeat_count`·`GAP` cycles.
- Asserting `resetn` mid-run clears all outputs immediately, independent of the clock. Release of `resetn` is synchronized externally. The first edge after release is an IDLE cycle.
- `err` and `done` are never high in the same cycle.

## Test plan
- `pattern`=8'b0000_1101, `length`=4, `repeat_count`=0, `tick`=1, `start` pulse at edge 0:
  - `w_out` = 1,1,0,1 on edges 0–3.
  - `done`=1 at edge 4 only; `busy` is 0 from edge 4.
- Same pattern with `repeat_count`=1 and `GAP`=2:
  - `w_out` = 1,1,0,1,0,0,1,1,0,1.
  - `valid` = 0 during the two gap bits.
  - `done` at edge 10.
- `tick` high on every third cycle, `pattern`=8'b1011_0111, `length`=8:
  - Each bit is held for 3 cycles.
  - Sequence is 1,0,1,1,0,1,1,1.
  - `done` follows the 8th consuming tick by one cycle.
- `start` with `length`=0, then with `length`=9:
  - One-cycle `err` pulse each time.
  - `busy`, `valid` and `w_out` stay 0.
- `start` pulsed and `pattern` changed mid-run: the output stream is unchanged and the second `start` is ignored. A new `start` in the `done` cycle begins a new run at the next edge.
- `resetn` driven low between clock edges during bit 2: all outputs go to 0 immediately. After release, the block is IDLE and a fresh `start` transmits correctly.
